sram_arbiter: RTL and testbench

- 16-requester arbiter used by the SRAM controller to select one request lane per clock.
- The 256-bit input bus carries 16 packed 16-bit request lanes.
- Mode input sp0_wrr1 selects strict priority (0) or weighted round robin (1).
- Registered output forwards only the winning lane in place; all other lanes are zeroed.

---
 rtl/sram_arbiter_if.sv | 21 ++
 rtl/sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Request/grant bus between the SRAM controller and its lane arbiter.
// The master drives mode and the packed request lanes; the slave returns the registered result.
interface sram_arbiter_if #(
  parameter int unsigned arbiter_data_width = 256
);
  logic                          sp0_wrr1;
  logic [arbiter_data_width-1:0] data_in;
  logic [arbiter_data_width-1:0] data_out;

  modport master (
    output sp0_wrr1,
    output data_in,
    input  data_out
  );

  modport slave (
    input  sp0_wrr1,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/sram_arbiter.sv
// 16-lane request arbiter. Each cycle one valid lane is chosen, either by strict priority
// (largest priority field, lowest index on ties) or by weighted round robin (a lane keeps
// winning for up to its weight in consecutive cycles). The winning lane is forwarded in place
// on a registered bus with every other lane zeroed.
module sram_arbiter #(
  parameter int unsigned arbiter_data_width = 256,
  parameter int unsigned NUM_REQ            = 16
) (
  input logic          clk,
  input logic          rst,
  sram_arbiter_if.slave bus
);

  localparam int unsigned LaneW = 16;

  // Lane field decode
  logic [LaneW-1:0] lane     [NUM_REQ];
  logic             req      [NUM_REQ];
  logic [2:0]       prio     [NUM_REQ];

  // Arbitration state
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  credit_q, credit_d;
  logic [3:0]  cur_q, cur_d;
  logic        cur_valid_q, cur_valid_d;
  logic [arbiter_data_width-1:0] data_out_q, data_out_d;

  // Winner selection results
  logic        sp_found;
  logic [3:0]  sp_idx;
  logic [2:0]  sp_prio;
  logic        rr_found;
  logic [3:0]  rr_idx;
  logic [3:0]  rr_probe;
  logic        cont;
  logic        grant;
  logic [3:0]  win;
  logic [3:0]  win_weight;
  logic [3:0]  eff_weight;

  // Split the packed bus into lanes and pull out the valid/priority fields
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lane[i] = bus.data_in[LaneW*i +: LaneW];
      req[i]  = lane[i][15];
      prio[i] = lane[i][14:12];
    end
  end

  // Strict priority: strictly-greater replacement keeps the lowest index on ties
  always_comb begin
    sp_found = 1'b0;
    sp_idx   = 4'd0;
    sp_prio  = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (!sp_found || (prio[i] > sp_prio))) begin
        sp_found = 1'b1;
        sp_idx   = 4'(i);
        sp_prio  = prio[i];
      end
    end
  end

  // Round robin search: first requesting lane starting at ptr, wrapping mod 16
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = 4'd0;
    rr_probe = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_probe = ptr_q + 4'(k);
      if (!rr_found && req[rr_probe]) begin
        rr_found = 1'b1;
        rr_idx   = rr_probe;
      end
    end
  end

  // Next-state: pick the winner for the active mode and update pointer/credit/owner
  always_comb begin
    ptr_d       = ptr_q;
    credit_d    = 4'd0;
    cur_d       = cur_q;
    cur_valid_d = 1'b0;
    grant       = 1'b0;
    win         = 4'd0;
    cont        = 1'b0;
    win_weight  = 4'd0;
    eff_weight  = 4'd1;

    if (!bus.sp0_wrr1) begin
      // Strict priority never carries credit, so a later switch to WRR starts a fresh search
      if (sp_found) begin
        grant = 1'b1;
        win   = sp_idx;
        ptr_d = sp_idx + 4'd1;
      end
    end else begin
      cont = cur_valid_q && req[cur_q] && (credit_q != 4'd0);
      if (cont) begin
        grant       = 1'b1;
        win         = cur_q;
        credit_d    = credit_q - 4'd1;
        cur_valid_d = 1'b1;
      end else if (rr_found) begin
        grant       = 1'b1;
        win         = rr_idx;
        win_weight  = lane[rr_idx][11:8];
        eff_weight  = (win_weight == 4'd0) ? 4'd1 : win_weight;
        credit_d    = eff_weight - 4'd1;
        cur_d       = rr_idx;
        cur_valid_d = 1'b1;
        ptr_d       = rr_idx + 4'd1;
      end
    end
  end

  // Output image: winner lane copied to its own slot, all others cleared
  always_comb begin
    data_out_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && (win == 4'(i))) begin
        data_out_d[LaneW*i +: LaneW] = lane[i];
      end
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= 4'd0;
      credit_q    <= 4'd0;
      cur_q       <= 4'd0;
      cur_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      credit_q    <= credit_d;
      cur_q       <= cur_d;
      cur_valid_q <= cur_valid_d;
      data_out_q  <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: each driven cycle pushes the hand-derived expected
// output image, which is popped and compared one cycle later, away from the clock edge.
module tb_sram_arbiter;

  localparam int unsigned W = 256;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [W-1:0] exp_q [$];

  sram_arbiter_if #(.arbiter_data_width(W)) bus ();

  sram_arbiter #(
    .arbiter_data_width(W),
    .NUM_REQ           (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] lane(input int idx, input logic [15:0] val);
    logic [W-1:0] v;
    v = '0;
    v[16*idx +: 16] = val;
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, push its expected result, compare after the edge
  task automatic step(input string tag, input logic sp, input logic [W-1:0] din,
                      input logic [W-1:0] exp);
    logic [W-1:0] e;
    bus.sp0_wrr1 = sp;
    bus.data_in  = din;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, bus.data_out, '1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, bus.data_out, e);
    end
  endtask

  logic [W-1:0] din;

  initial begin
    checks = 0;
    errors = 0;
    rst          = 1'b0;
    bus.sp0_wrr1 = 1'b0;
    bus.data_in  = lane(3, 16'hF0F3);
    #3;
    check_eq("reset_out", bus.data_out, '0);
    #9 rst = 1'b1;  // released between edges (t=12)
    #1;

    // Strict priority: lane5 (prio6) beats lane2 (prio3)
    din = lane(2, 16'hB105) | lane(5, 16'hE2AA);
    step("sp_prio_0", 1'b0, din, lane(5, 16'hE2AA));
    step("sp_prio_1", 1'b0, din, lane(5, 16'hE2AA));

    // Equal priority: lowest index wins, stable while held
    din = lane(1, 16'hD101) | lane(4, 16'hD104);
    for (int i = 0; i < 3; i++) step($sformatf("sp_tie_%0d", i), 1'b0, din, lane(1, 16'hD101));

    // Asynchronous reset mid-traffic clears the output without an edge
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst", bus.data_out, '0);
    bus.sp0_wrr1 = 1'b1;
    din = lane(0, 16'h8200) | lane(3, 16'h8103);
    bus.data_in = din;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_release_no_edge", bus.data_out, '0);

    // WRR from ptr=0: lane0 weight2, lane3 weight1 -> 0,0,3,0,0,3
    for (int r = 0; r < 2; r++) begin
      step($sformatf("wrr_w_%0d_a", r), 1'b1, din, lane(0, 16'h8200));
      step($sformatf("wrr_w_%0d_b", r), 1'b1, din, lane(0, 16'h8200));
      step($sformatf("wrr_w_%0d_c", r), 1'b1, din, lane(3, 16'h8103));
    end

    // Weight 0 behaves as 1: lane7 alone granted every cycle (ptr now 4)
    din = lane(7, 16'h8007);
    for (int i = 0; i < 3; i++) step($sformatf("wrr_w0_%0d", i), 1'b1, din, lane(7, 16'h8007));

    // Adding lane9 with ptr=8: 9,7,9,7
    din = lane(7, 16'h8007) | lane(9, 16'h8009);
    for (int i = 0; i < 2; i++) begin
      step($sformatf("wrr_alt_%0d_9", i), 1'b1, din, lane(9, 16'h8009));
      step($sformatf("wrr_alt_%0d_7", i), 1'b1, din, lane(7, 16'h8007));
    end

    // No candidates
    step("none_0", 1'b1, '0, '0);
    step("none_1", 1'b1, '0, '0);

    // Mode switch: lane0 weight3 granted once (ptr 8 wraps to 0), SP picks lane6, ptr -> 7
    step("sw_wrr0", 1'b1, lane(0, 16'h8300), lane(0, 16'h8300));
    din = lane(0, 16'h8300) | lane(6, 16'hF006);
    step("sw_sp6", 1'b0, din, lane(6, 16'hF006));
    // Back in WRR: credit discarded, search from 7 -> lane8, then wrap to lane0 for 3 grants
    din = lane(0, 16'h8300) | lane(6, 16'hF006) | lane(8, 16'h8008);
    step("sw_back8", 1'b1, din, lane(8, 16'h8008));
    step("sw_back0a", 1'b1, din, lane(0, 16'h8300));
    step("sw_back0b", 1'b1, din, lane(0, 16'h8300));
    step("sw_back0c", 1'b1, din, lane(0, 16'h8300));
    step("sw_back6", 1'b1, din, lane(6, 16'hF006));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
